dp_sched_ctrl: RTL and testbench
================================

// Module: dp_sched_ctrl
// PURPOSE
//  Microprogrammed sequencer for the single-ALU/MUL/LOG scheduled datapath.
//  Holds a programmable schedule of control words and plays it back on start, one word per cycle.
//  Each word drives all operand mux selects, unit opcodes, intermediate-register enables, result_en and done_next.
//  Sits between the top-level host (start/busy/program port) and the datapath control inputs.
// PARAMETERS
//  DEPTH     16  schedule slots (power of 2, >=2)
//  AW         4  slot address width = log2(DEPTH)
//  NREG       7  intermediate-register enables per word
//  CW        37  control word width = 24 sel + 1 alu_op + 1 mul_op + 2 log_op + NREG + result_en + last
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      reset, asynchronous, active-low
//  start        in   1      one-cycle request to run schedule; honoured only in IDLE
//  abort        in   1      terminate a running schedule
//  busy         out  1      high in RUN
//  err          out  1      sticky: schedule overran DEPTH without last, or cfg write while busy; cleared by start
//  cfg_we       in   1      schedule write strobe
//  cfg_addr     in   AW     slot to write
//  cfg_wdata    in   CW     control word
//  alu1_sel1/alu1_sel2/mul1_sel1/mul1_sel2/log1_sel1/log1_sel2  out 4 each  operand mux selects
//  alu1_op  out 1;  mul1_op  out 1;  log1_op  out 2          unit opcodes
//  reg_en       out  NREG   {log14,alu13,log12,mul9,mul6,alu5,alu2} enables, bit0 = alu2
//  result_en    out  1      copy reg_log14 to result
//  done_next    out  1      datapath done flag input
// BEHAVIOUR
//  Reset: state IDLE, pc=0, err=0, all schedule slots = 0; every control output 0.
//  Word layout [36:0], MSB first: alu1_sel1, alu1_sel2, alu1_op, mul1_sel1, mul1_sel2, mul1_op, log1_sel1, log1_sel2, log1_op[1:0], reg_en[6:0], result_en, last.
//  FSM: IDLE -> RUN on start; RUN -> IDLE after a word with last=1, on abort, or on overrun.
//  In IDLE, all control outputs are forced to 0; datapath registers hold.
//  In RUN, outputs are combinational from slot[pc]; pc increments every cycle.
//    - Latency: the first word is applied in the cycle after start sampled.
//    - An N-word schedule keeps busy high for exactly N cycles.
//  Last word: done_next = 1 in the same cycle (done and result update on the same edge); pc returns to 0; next state IDLE.
//    - done_next is never 1 outside the last-word cycle.
//  Overrun: pc = DEPTH-1 with last=0 -> that word still executes with result_en and done_next forced 0; err set; pc=0; IDLE.
//  abort in RUN: all outputs 0 in that same cycle (abort wins over the word); pc=0; IDLE; err unchanged.
//  start while busy: ignored. Simultaneous start+abort in IDLE: start wins.
//  cfg_we in IDLE: slot[cfg_addr] <= cfg_wdata next edge; usable by a start in the following cycle.
//  cfg_we in RUN: write dropped, err set.
//  Sel codes 15 and log1_op 2'b11 are passed through unchanged (datapath yields 0).
//  Reset mid-run: immediate return to reset state; the schedule is lost and must be reprogrammed.
// CONFIGURATION
//  DP_SCHED_STEP_EN defined:
//    - adds input `step` (1 bit); in RUN, pc advances only in cycles with step=1.
//    - reg_en, result_en and done_next are ANDed with step; selects and opcodes hold slot[pc].
//    - abort and overrun rules are unchanged.
//  Not defined: no step port; free-running, one word per cycle.
// STRUCTURE
//  Package dp_sched_pkg holds:
//    - ctrl_word_t packed struct and CW/NREG constants
//    - state_t enum {IDLE, RUN}
//    - REG_ALU2..REG_LOG14 enable bit indices and SEL_I1..SEL_LOG14 mux codes (0..14)
//  Sub-module dp_sched_mem: DEPTH x CW flop array, async-low cleared, 1 write port, 1 combinational read port.
//  Top level holds the FSM, pc, err and output gating.
// TESTING
//  1. Reset, no programming, start: busy high 16 cycles, all outputs 0, then err=1, done_next never 1.
//  2. Program 3 words (slot2 last=1, result_en=1, reg_en=7'h40), start: busy 3 cycles; done_next=1 and result_en=1 only in cycle 3.
//  3. Full 7-op schedule against the datapath, i1..i8 = 1..8: result equals the golden model; done pulses exactly once.
//  4. abort in cycle 2 of a 5-word run: outputs 0 in that cycle, IDLE next, no done_next; restart runs from slot 0.
//  5. cfg_we during RUN: slot unchanged, err=1; next start clears err.
//  6. DP_SCHED_STEP_EN: step every 3rd cycle, 2-word schedule: each reg_en pulse lasts 1 cycle; busy spans 6 cycles.

Source files
------------

// File: rtl/dp_sched_pkg.sv
// Shared types and constants for the dp_sched_ctrl schedule sequencer.
// Optional single-step playback is enabled by defining DP_SCHED_STEP_EN.
package dp_sched_pkg;

    localparam int SCHED_DEPTH = 16;
    localparam int SCHED_AW    = 4;
    localparam int NREG        = 7;
    localparam int CW          = 37;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Field order is the bit layout of a schedule word, MSB first.
    typedef struct packed {
        logic [3:0]      alu1_sel1;
        logic [3:0]      alu1_sel2;
        logic            alu1_op;
        logic [3:0]      mul1_sel1;
        logic [3:0]      mul1_sel2;
        logic            mul1_op;
        logic [3:0]      log1_sel1;
        logic [3:0]      log1_sel2;
        logic [1:0]      log1_op;
        logic [NREG-1:0] reg_en;
        logic            result_en;
        logic            last;
    } ctrl_word_t;

    localparam int REG_ALU2  = 0;
    localparam int REG_ALU5  = 1;
    localparam int REG_MUL6  = 2;
    localparam int REG_MUL9  = 3;
    localparam int REG_LOG12 = 4;
    localparam int REG_ALU13 = 5;
    localparam int REG_LOG14 = 6;

    localparam logic [3:0] SEL_I1    = 4'd0;
    localparam logic [3:0] SEL_I2    = 4'd1;
    localparam logic [3:0] SEL_I3    = 4'd2;
    localparam logic [3:0] SEL_I4    = 4'd3;
    localparam logic [3:0] SEL_I5    = 4'd4;
    localparam logic [3:0] SEL_I6    = 4'd5;
    localparam logic [3:0] SEL_I7    = 4'd6;
    localparam logic [3:0] SEL_I8    = 4'd7;
    localparam logic [3:0] SEL_ALU2  = 4'd8;
    localparam logic [3:0] SEL_ALU5  = 4'd9;
    localparam logic [3:0] SEL_MUL6  = 4'd10;
    localparam logic [3:0] SEL_MUL9  = 4'd11;
    localparam logic [3:0] SEL_LOG12 = 4'd12;
    localparam logic [3:0] SEL_ALU13 = 4'd13;
    localparam logic [3:0] SEL_LOG14 = 4'd14;

    // Keeps operand selects and opcodes but drops every state-changing strobe.
    function automatic ctrl_word_t strip_commit(input ctrl_word_t w);
        ctrl_word_t r;
        r           = w;
        r.reg_en    = '0;
        r.result_en = 1'b0;
        r.last      = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/dp_sched_ctrl_if.sv
// Host and datapath-control bundle of dp_sched_ctrl; the step input exists
// only when DP_SCHED_STEP_EN is defined.
interface dp_sched_ctrl_if;
    import dp_sched_pkg::*;

    logic                start;
    logic                abort;
    logic                busy;
    logic                err;
    logic                cfg_we;
    logic [SCHED_AW-1:0] cfg_addr;
    logic [CW-1:0]       cfg_wdata;
`ifdef DP_SCHED_STEP_EN
    logic                step;
`endif

    logic [3:0]          alu1_sel1;
    logic [3:0]          alu1_sel2;
    logic [3:0]          mul1_sel1;
    logic [3:0]          mul1_sel2;
    logic [3:0]          log1_sel1;
    logic [3:0]          log1_sel2;
    logic                alu1_op;
    logic                mul1_op;
    logic [1:0]          log1_op;
    logic [NREG-1:0]     reg_en;
    logic                result_en;
    logic                done_next;

    modport master (
`ifdef DP_SCHED_STEP_EN
        output step,
`endif
        output start, abort, cfg_we, cfg_addr, cfg_wdata,
        input  busy, err,
        input  alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2, log1_sel1, log1_sel2,
        input  alu1_op, mul1_op, log1_op, reg_en, result_en, done_next
    );

    modport slave (
`ifdef DP_SCHED_STEP_EN
        input  step,
`endif
        input  start, abort, cfg_we, cfg_addr, cfg_wdata,
        output busy, err,
        output alu1_sel1, alu1_sel2, mul1_sel1, mul1_sel2, log1_sel1, log1_sel2,
        output alu1_op, mul1_op, log1_op, reg_en, result_en, done_next
    );

endinterface

// File: rtl/dp_sched_mem.sv
// Schedule store: DEPTH control words in flops, cleared by reset,
// one synchronous write port and one combinational read port.
module dp_sched_mem
    import dp_sched_pkg::*;
#(
    parameter int DEPTH = SCHED_DEPTH,
    parameter int AW    = SCHED_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  ctrl_word_t    wdata,
    input  logic [AW-1:0] raddr,
    output ctrl_word_t    rdata
);

    ctrl_word_t mem_q [DEPTH];
    ctrl_word_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dp_sched_ctrl.sv
// Microprogrammed sequencer: plays a stored schedule of control words, one per
// cycle, into the datapath. Define DP_SCHED_STEP_EN for step-gated playback.
module dp_sched_ctrl
    import dp_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    dp_sched_ctrl_if.slave  bus
);

    localparam logic [SCHED_AW-1:0] LAST_PC = SCHED_AW'(SCHED_DEPTH - 1);

    state_t              state_q, state_d;
    logic [SCHED_AW-1:0] pc_q, pc_d;
    logic                err_q, err_d;
    logic                mem_we;
    logic                adv;
    ctrl_word_t          rd_word;
    ctrl_word_t          out_word;

`ifdef DP_SCHED_STEP_EN
    assign adv = bus.step;
`else
    assign adv = 1'b1;
`endif

    // Writes are only accepted while idle so a running schedule never changes under itself.
    assign mem_we = bus.cfg_we && (state_q == IDLE);

    dp_sched_mem #(
        .DEPTH (SCHED_DEPTH),
        .AW    (SCHED_AW)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (bus.cfg_addr),
        .wdata (ctrl_word_t'(bus.cfg_wdata)),
        .raddr (pc_q),
        .rdata (rd_word)
    );

    // out_word.last doubles as done_next: it survives only on a committed last word.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        err_d    = err_q;
        out_word = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    err_d   = 1'b0;
                end
            end
            RUN: begin
                if (bus.cfg_we) begin
                    err_d = 1'b1;
                end
                if (bus.abort) begin
                    state_d = IDLE;
                    pc_d    = '0;
                end else begin
                    out_word = rd_word;
                    if (!adv) begin
                        out_word = strip_commit(rd_word);
                    end else if (rd_word.last) begin
                        state_d = IDLE;
                        pc_d    = '0;
                    end else if (pc_q == LAST_PC) begin
                        out_word.result_en = 1'b0;
                        err_d              = 1'b1;
                        state_d            = IDLE;
                        pc_d               = '0;
                    end else begin
                        pc_d = pc_q + SCHED_AW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.err       = err_q;
    assign bus.alu1_sel1 = out_word.alu1_sel1;
    assign bus.alu1_sel2 = out_word.alu1_sel2;
    assign bus.alu1_op   = out_word.alu1_op;
    assign bus.mul1_sel1 = out_word.mul1_sel1;
    assign bus.mul1_sel2 = out_word.mul1_sel2;
    assign bus.mul1_op   = out_word.mul1_op;
    assign bus.log1_sel1 = out_word.log1_sel1;
    assign bus.log1_sel2 = out_word.log1_sel2;
    assign bus.log1_op   = out_word.log1_op;
    assign bus.reg_en    = out_word.reg_en;
    assign bus.result_en = out_word.result_en;
    assign bus.done_next = out_word.last;

endmodule

// File: tb/tb_dp_sched_ctrl.sv
// Directed self-checking bench for dp_sched_ctrl; the step scenario is built
// only when DP_SCHED_STEP_EN is defined.
module tb_dp_sched_ctrl;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    logic [36:0] exp_w [16];

    dp_sched_ctrl_if bus ();

    dp_sched_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs packed in schedule-word order, with done_next in the last position.
    wire [36:0] out_bits = {bus.alu1_sel1, bus.alu1_sel2, bus.alu1_op,
                            bus.mul1_sel1, bus.mul1_sel2, bus.mul1_op,
                            bus.log1_sel1, bus.log1_sel2, bus.log1_op,
                            bus.reg_en, bus.result_en, bus.done_next};

    function automatic logic [36:0] mk(input logic [3:0] a1, input logic [3:0] a2, input logic ao,
                                       input logic [3:0] m1, input logic [3:0] m2, input logic mo,
                                       input logic [3:0] l1, input logic [3:0] l2, input logic [1:0] lo,
                                       input logic [6:0] re, input logic res, input logic last);
        return {a1, a2, ao, m1, m2, mo, l1, l2, lo, re, res, last};
    endfunction

    task automatic write_slot(input logic [3:0] addr, input logic [36:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        @(posedge clk); #1;
        bus.cfg_we    = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.err !== 1'b0) $display("[TB] FAIL reset_err got %b want 0", bus.err);
        else pass_cnt++;
        total_cnt++;
        if (out_bits !== 37'h0) $display("[TB] FAIL reset_outputs got %h want 0", out_bits);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.busy, out_bits} !== 38'h0) $display("[TB] FAIL post_reset_idle got %h want 0", {bus.busy, out_bits});
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_empty_overrun();
        int busy_cyc = 0;
        int done_cyc = 0;
        int bad_out  = 0;
        logic b;
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            b = bus.busy;
            if (b === 1'b1) begin
                busy_cyc++;
                if (bus.done_next !== 1'b0) done_cyc++;
                if (out_bits !== 37'h0) bad_out++;
            end
            @(posedge clk); #1;
            if (b !== 1'b1) break;
        end
        total_cnt++;
        if (busy_cyc != 16) $display("[TB] FAIL overrun_busy_cycles got %0d want 16", busy_cyc);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc != 0) $display("[TB] FAIL overrun_done_cycles got %0d want 0", done_cyc);
        else pass_cnt++;
        total_cnt++;
        if (bad_out != 0) $display("[TB] FAIL overrun_outputs nonzero cycles %0d want 0", bad_out);
        else pass_cnt++;
        total_cnt++;
        if (bus.err !== 1'b1) $display("[TB] FAIL overrun_err got %b want 1", bus.err);
        else pass_cnt++;
    endtask

    // Plays slots from 0, checks each busy cycle against exp_w and counts the run.
    task automatic run_checked(input string name, input int nwords, input int want_err);
        int busy_cyc = 0;
        int done_cyc = 0;
        logic b;
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            b = bus.busy;
            if (b === 1'b1) begin
                if (busy_cyc < nwords) begin
                    total_cnt++;
                    if (out_bits !== exp_w[busy_cyc])
                        $display("[TB] FAIL %s_word%0d got %h want %h", name, busy_cyc, out_bits, exp_w[busy_cyc]);
                    else pass_cnt++;
                end
                if (bus.done_next === 1'b1) done_cyc++;
                busy_cyc++;
            end
            @(posedge clk); #1;
            if (b !== 1'b1) break;
        end
        total_cnt++;
        if (busy_cyc != nwords) $display("[TB] FAIL %s_busy_cycles got %0d want %0d", name, busy_cyc, nwords);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc != 1) $display("[TB] FAIL %s_done_pulses got %0d want 1", name, done_cyc);
        else pass_cnt++;
        total_cnt++;
        if (bus.err !== want_err[0]) $display("[TB] FAIL %s_err got %b want %0d", name, bus.err, want_err);
        else pass_cnt++;
    endtask

    task automatic test_three_word();
        exp_w[0] = mk(4'd0, 4'd1, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 2'b00, 7'h01, 1'b0, 1'b0);
        exp_w[1] = mk(4'd8, 4'd2, 1'b0, 4'd2, 4'd3, 1'b1, 4'd0, 4'd0, 2'b00, 7'h0A, 1'b0, 1'b0);
        exp_w[2] = mk(4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd9, 4'd12, 2'b01, 7'h40, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) write_slot(i[3:0], exp_w[i]);
        run_checked("three_word", 3, 0);
    endtask

    task automatic test_full_schedule();
        exp_w[0] = mk(4'd0, 4'd1, 1'b0, 4'd2, 4'd3, 1'b0, 4'd0, 4'd0, 2'b00, 7'h05, 1'b0, 1'b0);
        exp_w[1] = mk(4'd4, 4'd5, 1'b1, 4'd8, 4'd6, 1'b1, 4'd0, 4'd0, 2'b00, 7'h0A, 1'b0, 1'b0);
        exp_w[2] = mk(4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd10, 4'd11, 2'b10, 7'h10, 1'b0, 1'b0);
        exp_w[3] = mk(4'd15, 4'd7, 1'b0, 4'd15, 4'd15, 1'b0, 4'd15, 4'd9, 2'b11, 7'h00, 1'b0, 1'b0);
        exp_w[4] = mk(4'd9, 4'd12, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 2'b00, 7'h20, 1'b0, 1'b0);
        exp_w[5] = mk(4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd13, 4'd11, 2'b01, 7'h00, 1'b0, 1'b0);
        exp_w[6] = mk(4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd13, 4'd12, 2'b01, 7'h40, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) write_slot(i[3:0], exp_w[i]);
        run_checked("full_sched", 7, 0);
    endtask

    task automatic test_abort();
        exp_w[4] = mk(4'd9, 4'd12, 1'b0, 4'd0, 4'd0, 1'b0, 4'd14, 4'd1, 2'b00, 7'h40, 1'b1, 1'b1);
        write_slot(4'd4, exp_w[4]);
        pulse_start();
        @(negedge clk);
        total_cnt++;
        if (out_bits !== exp_w[0]) $display("[TB] FAIL abort_cycle1 got %h want %h", out_bits, exp_w[0]);
        else pass_cnt++;
        @(posedge clk); #1;
        bus.abort = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({bus.busy, out_bits} !== {1'b1, 37'h0})
            $display("[TB] FAIL abort_cycle2 got %h want %h", {bus.busy, out_bits}, {1'b1, 37'h0});
        else pass_cnt++;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({bus.busy, bus.err} !== 2'b00) $display("[TB] FAIL abort_idle got %b want 00", {bus.busy, bus.err});
        else pass_cnt++;
        @(posedge clk); #1;
        run_checked("abort_restart", 5, 0);
    endtask

    task automatic test_cfg_in_run();
        int busy_cyc = 0;
        logic b;
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            b = bus.busy;
            if (b === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            if (c == 0) begin
                bus.cfg_we    = 1'b1;
                bus.cfg_addr  = 4'd0;
                bus.cfg_wdata = '1;
            end else begin
                bus.cfg_we = 1'b0;
            end
            if (b !== 1'b1) break;
        end
        total_cnt++;
        if (busy_cyc != 5) $display("[TB] FAIL cfg_run_busy_cycles got %0d want 5", busy_cyc);
        else pass_cnt++;
        total_cnt++;
        if (bus.err !== 1'b1) $display("[TB] FAIL cfg_run_err got %b want 1", bus.err);
        else pass_cnt++;
        run_checked("cfg_run_restart", 5, 0);
    endtask

`ifdef DP_SCHED_STEP_EN
    task automatic test_step();
        int busy_cyc = 0;
        int reg_cyc  = 0;
        int done_cyc = 0;
        int c        = 1;
        logic b;
        write_slot(4'd0, mk(4'd0, 4'd1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 2'b00, 7'h01, 1'b0, 1'b0));
        write_slot(4'd1, mk(4'd8, 4'd2, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 2'b00, 7'h40, 1'b1, 1'b1));
        bus.step = 1'b0;
        pulse_start();
        for (int k = 0; k < 40; k++) begin
            bus.step = ((c % 3) == 0);
            @(negedge clk);
            b = bus.busy;
            if (b === 1'b1) begin
                busy_cyc++;
                if (bus.reg_en !== 7'h00) reg_cyc++;
                if (bus.done_next === 1'b1) done_cyc++;
            end
            @(posedge clk); #1;
            c++;
            if (b !== 1'b1) break;
        end
        bus.step = 1'b1;
        total_cnt++;
        if (busy_cyc != 6) $display("[TB] FAIL step_busy_cycles got %0d want 6", busy_cyc);
        else pass_cnt++;
        total_cnt++;
        if (reg_cyc != 2) $display("[TB] FAIL step_reg_en_cycles got %0d want 2", reg_cyc);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc != 1) $display("[TB] FAIL step_done_pulses got %0d want 1", done_cyc);
        else pass_cnt++;
    endtask
`endif

    task automatic test_reset_midrun();
        int busy_cyc = 0;
        logic b;
        pulse_start();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({bus.busy, bus.err, out_bits} !== 39'h0)
            $display("[TB] FAIL midrun_reset got %h want 0", {bus.busy, bus.err, out_bits});
        else pass_cnt++;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            b = bus.busy;
            if (b === 1'b1) begin
                if (busy_cyc == 0) begin
                    total_cnt++;
                    if (out_bits !== 37'h0) $display("[TB] FAIL midrun_slot_cleared got %h want 0", out_bits);
                    else pass_cnt++;
                end
                busy_cyc++;
            end
            @(posedge clk); #1;
            if (b !== 1'b1) break;
        end
        total_cnt++;
        if (busy_cyc != 16) $display("[TB] FAIL midrun_busy_cycles got %0d want 16", busy_cyc);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_wdata = '0;
`ifdef DP_SCHED_STEP_EN
        bus.step      = 1'b1;
`endif
        test_reset();
        test_empty_overrun();
        test_three_word();
        test_full_schedule();
        test_abort();
        test_cfg_in_run();
`ifdef DP_SCHED_STEP_EN
        test_step();
`endif
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
